// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared defaults and half-period helper for the programmable clock divider
package clkdiv_pkg;

    localparam int DIV_W_DEF     = 8;
    localparam int DIV_RESET_DEF = 2;

    // Number of high cycles per period: ceil(N/2), so odd divisors lean high
    function automatic int unsigned half_period(input int unsigned n);
        return (n + 1) / 2;
    endfunction

endpackage

// File: rtl/clkdiv_load_ctrl.sv
// clkdiv_load_ctrl: capture/pending/acknowledge handshake for a new divisor
module clkdiv_load_ctrl import clkdiv_pkg::*; #(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] i_div_in,
    input  logic             i_div_load,
    input  logic             i_apply,
    output logic             o_busy,
    output logic             o_div_ack,
    output logic [DIV_W-1:0] o_pend
);

    logic             r_busy;
    logic             r_ack;
    logic [DIV_W-1:0] r_pend;
    logic             w_take;
    logic [DIV_W-1:0] w_clamped;

    assign w_take    = i_apply && r_busy;
    assign w_clamped = (i_div_in == '0) ? DIV_W'(1) : i_div_in;

    // Hold one pending divisor until the counter's next wrap consumes it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_ack  <= 1'b0;
            r_pend <= '0;
        end else begin
            r_ack <= w_take;
            if (w_take) begin
                r_busy <= 1'b0;
            end else if (!r_busy && i_div_load) begin
                r_busy <= 1'b1;
                r_pend <= w_clamped;
            end
        end
    end

    assign o_busy    = r_busy;
    assign o_div_ack = r_ack;
    assign o_pend    = r_pend;

endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable integer clock divider with glitch-free divisor reload
// Optional feature: define CLKDIV_PHASE_SYNC_EN to add the sync input (forced wrap).
module clk_div_prog import clkdiv_pkg::*; #(
    parameter int DIV_W     = DIV_W_DEF,
    parameter int DIV_RESET = DIV_RESET_DEF
) (
    input  logic             clk,
    input  logic             reset,
`ifdef CLKDIV_PHASE_SYNC_EN
    input  logic             sync,
`endif
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_load,
    output logic             busy,
    output logic             div_ack,
    output logic             tick,
    output logic             clk_out
);

    logic [DIV_W-1:0] r_n;
    logic [DIV_W-1:0] r_count;
    logic             r_tick;
    logic             r_clk_out;
    logic             w_wrap;
    logic             w_apply;
    logic             w_busy;
    logic [DIV_W-1:0] w_pend;
    logic [DIV_W-1:0] w_n_next;
    logic [DIV_W-1:0] w_count_next;
    logic [DIV_W-1:0] w_half;

    assign w_wrap = (r_count == r_n - DIV_W'(1));
`ifdef CLKDIV_PHASE_SYNC_EN
    assign w_apply = w_wrap || sync;
`else
    assign w_apply = w_wrap;
`endif
    assign w_n_next     = (w_apply && w_busy) ? w_pend : r_n;
    assign w_count_next = w_apply ? '0 : r_count + DIV_W'(1);
    assign w_half       = DIV_W'(half_period(32'(w_n_next)));

    clkdiv_load_ctrl #(.DIV_W(DIV_W)) u_load_ctrl (
        .clk        (clk),
        .reset      (reset),
        .i_div_in   (div_in),
        .i_div_load (div_load),
        .i_apply    (w_apply),
        .o_busy     (w_busy),
        .o_div_ack  (div_ack),
        .o_pend     (w_pend)
    );

    // Count modulo N; outputs are registered from the next-state count and divisor
    always_ff @(posedge clk) begin
        if (reset) begin
            r_n       <= DIV_W'(DIV_RESET);
            r_count   <= '0;
            r_tick    <= 1'b0;
            r_clk_out <= 1'b0;
        end else begin
            r_n       <= w_n_next;
            r_count   <= w_count_next;
            r_tick    <= w_apply;
            r_clk_out <= (w_count_next < w_half);
        end
    end

    assign busy    = w_busy;
    assign tick    = r_tick;
    assign clk_out = r_clk_out;

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 The block SHALL have parameter DIV_W, default 8, giving the divisor and counter width in bits.
REQ-002 The block SHALL have parameter DIV_RESET, default 2, giving the divisor active after reset; legal range is 1..2^DIV_W-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the master clock; there is one clock, and all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port div_in, input, DIV_W bits: the requested divisor N.
REQ-006 The block SHALL have port div_load, input, 1 bit: a one-cycle request to load div_in.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a captured divisor is pending.
REQ-008 The block SHALL have port div_ack, output, 1 bit: a one-cycle pulse in the first cycle a new divisor is active.
REQ-009 The block SHALL have port tick, output, 1 bit: a one-cycle pulse once per divided period.
REQ-010 The block SHALL have port clk_out, output, 1 bit: a registered divided square wave.

Function
REQ-011 The block SHALL hold the active divisor N and a counter count in 0..N-1.
- count_next = 0 when count==N-1, otherwise count+1.
REQ-012 On each edge the block SHALL register tick <= (count==N-1), so tick is high in the cycle where count==0 after a wrap.
REQ-013 On each edge the block SHALL register clk_out <= (count_next < H), where H=(N+1)/2 with integer division.
- Even N gives 50% duty.
- Odd N gives (N+1)/2 cycles high and (N-1)/2 cycles low.
- N=1 gives clk_out constantly 1 and tick every cycle.
REQ-014 A div_in value of 0 SHALL be clamped to 1 at capture.
REQ-015 When busy==0 and div_load==1, the block SHALL capture div_in into a pending register and set busy on that edge.
REQ-016 div_load asserted while busy==1 SHALL be ignored; the first pending value is kept.
REQ-017 A pending divisor SHALL become active only on a wrap edge (count==N-1), never mid-period.
- On that edge count<=0, clk_out is computed with the new N, and busy<=0.
- div_ack<=1 on that edge, for one cycle.
REQ-018 A load captured on the same edge as a wrap SHALL NOT apply at that wrap; it applies at the following wrap.
REQ-019 Loading a divisor equal to the active one SHALL still complete the full handshake (busy, then div_ack).
REQ-020 The counter SHALL wrap modulo N only; count never exceeds N-1, including at N=2^DIV_W-1.

Reset
REQ-021 While reset==1 the block SHALL set count=0, N=DIV_RESET, pending cleared, busy=0, div_ack=0, tick=0, clk_out=0.
REQ-022 Reset SHALL take priority over div_load and sync.
- Reset asserted mid-period or during a pending load discards that load; no div_ack is issued for it.
REQ-023 After reset is released, the first tick SHALL occur on the N-th edge (N=DIV_RESET).

Configuration
REQ-024 With macro CLKDIV_PHASE_SYNC_EN defined, the block SHALL add input sync (1 bit), which forces a wrap on the next edge.
- On that edge: count<=0, tick<=1, clk_out<=1.
- A pending divisor is applied on that edge, with div_ack.
REQ-025 Without CLKDIV_PHASE_SYNC_EN, the sync port and its logic SHALL be absent, and behaviour is exactly REQ-011..023.

Structure
REQ-026 The shared package clkdiv_pkg SHALL hold the DIV_W and DIV_RESET defaults and the half-period function H(N).
REQ-027 The capture/pending/ack handshake SHALL be a sub-module, clkdiv_load_ctrl; the counter and output logic stay in clk_div_prog.

Verification
REQ-028 Reset with defaults, then release: clk_out reads 0,0,1,0,1,0…; tick is high on edges 2,4,6…; the 100 MHz clk gives a 50 MHz clk_out.
REQ-029 Load 5 mid-period while N=2: busy stays high until the next wrap; div_ack pulses once; then tick has period 5 and clk_out runs 3 cycles high, 2 low.
REQ-030 Load 0: the clamp gives N=1; after div_ack, tick and clk_out stay continuously high.
REQ-031 Load 7, then load 3 while busy: only 7 is applied; tick period is 7; exactly one div_ack.
REQ-032 Assert reset 1 cycle with a load of 9 pending at N=4: no div_ack; N returns to 2; the first tick comes 2 edges after release.
REQ-033 With CLKDIV_PHASE_SYNC_EN at N=6 and count=2, assert sync: the next cycle has count=0, tick=1, clk_out=1, and the 6-cycle period restarts from there.
